// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: access sizes, LSU states and the datapath width.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } mem_size_t;

    typedef enum logic {
        LSU_IDLE,
        LSU_WAIT
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: lane enables and replicated store data, plus
// right-shift and sign/zero extension of the addressed word for loads.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]      i_size,
    input  logic [1:0]      i_offset,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rword,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_misalign
);

    logic [XLEN-1:0] w_shift;

    always_comb begin
        w_shift    = i_rword >> {i_offset, 3'b000};
        o_be       = 4'b0000;
        o_wdata    = '0;
        o_rdata    = '0;
        o_misalign = 1'b0;
        case (i_size)
            SIZE_B: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shift[7] & ~i_unsigned}}, w_shift[7:0]};
            end
            SIZE_H: begin
                o_misalign = i_offset[0];
                o_be       = 4'b0011 << i_offset;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{w_shift[15] & ~i_unsigned}}, w_shift[15:0]};
            end
            // 2'b11 decodes as a word access
            default: begin
                o_misalign = (i_offset != 2'b00);
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_rdata    = i_rword;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit with a byte-addressed little-endian data memory and an optional
// wait-state counter that holds off new requests while a slow access is pending.
module data_mem_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    input  logic            i_req_we,
    input  logic [1:0]      i_req_size,
    input  logic            i_req_unsigned,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_req_ready,
    output logic            o_stall,
    output logic            o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_misalign_err
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    lsu_state_t      r_state;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_addr;
    logic [1:0]      r_size;
    logic            r_we;
    logic            r_unsigned;
    logic [XLEN-1:0] r_wdata;
    logic [7:0]      r_mem [DEPTH_BYTES];

    logic            w_wait;
    logic            w_accept;
    logic            w_direct;
    logic            w_commit;
    logic            w_mem_wr;
    logic [AW-1:0]   w_addr;
    logic [AW-3:0]   w_word_idx;
    logic [1:0]      w_size;
    logic            w_we;
    logic            w_unsigned;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_rword;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_sh;
    logic [XLEN-1:0] w_rdata_ext;
    logic            w_misalign;
    logic            w_unused_addr;

    assign w_unused_addr = ^i_req_addr[XLEN-1:AW];

    assign w_wait      = (r_state == LSU_WAIT);
    assign w_accept    = i_req_valid && !w_wait;
    assign o_req_ready = !w_wait;
    assign o_stall     = i_req_valid && w_wait;

    // In WAIT the access is driven from the latched request, otherwise from the live one
    assign w_addr     = w_wait ? r_addr     : i_req_addr[AW-1:0];
    assign w_size     = w_wait ? r_size     : i_req_size;
    assign w_we       = w_wait ? r_we       : i_req_we;
    assign w_unsigned = w_wait ? r_unsigned : i_req_unsigned;
    assign w_wdata    = w_wait ? r_wdata    : i_req_wdata;
    assign w_word_idx = w_addr[AW-1:2];

    assign w_rword = {r_mem[{w_word_idx, 2'd3}], r_mem[{w_word_idx, 2'd2}],
                      r_mem[{w_word_idx, 2'd1}], r_mem[{w_word_idx, 2'd0}]};

    lsu_align u_align (
        .i_size     (w_size),
        .i_offset   (w_addr[1:0]),
        .i_unsigned (w_unsigned),
        .i_wdata    (w_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata_ext),
        .o_misalign (w_misalign)
    );

    assign w_direct = w_accept && (w_misalign || WAIT_CYCLES == 0);
    assign w_commit = w_direct || (w_wait && r_cnt == 4'd1);
    // Reset gating keeps a request presented during reset from reaching the array
    assign w_mem_wr = w_commit && w_we && !w_misalign && i_rst_n;

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_mem_wr && w_be[k]) begin
                r_mem[{w_word_idx, 2'(k)}] <= w_wdata_sh[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= LSU_IDLE;
            r_cnt          <= 4'd0;
            r_addr         <= '0;
            r_size         <= 2'b00;
            r_we           <= 1'b0;
            r_unsigned     <= 1'b0;
            r_wdata        <= '0;
            o_rsp_valid    <= 1'b0;
            o_rsp_rdata    <= '0;
            o_misalign_err <= 1'b0;
        end else begin
            o_rsp_valid    <= w_commit;
            o_misalign_err <= w_commit && w_misalign;
            o_rsp_rdata    <= (w_commit && !w_we && !w_misalign) ? w_rdata_ext : '0;
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept && !w_direct) begin
                        r_addr     <= i_req_addr[AW-1:0];
                        r_size     <= i_req_size;
                        r_we       <= i_req_we;
                        r_unsigned <= i_req_unsigned;
                        r_wdata    <= i_req_wdata;
                        r_cnt      <= 4'(WAIT_CYCLES);
                        r_state    <= LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= LSU_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Load/store unit plus byte-addressed data memory for the RISC-V core. It sits downstream of the execute stage (address from ALU, store data from rs2) and feeds the write-back stage with load data. It handles byte, halfword and word accesses in little-endian order, with sign or zero extension on loads and misalignment detection. An optional wait-state counter emulates slow memory and stalls the pipeline.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; must be a power of 2.
WAIT_CYCLES, 0, extra cycles between request accept and memory access; range 0..15.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active low.
req_valid  in  1  access request from the execute stage.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
req_unsigned  in  1  load zero-extends when 1 (LBU/LHU); ignored for stores.
req_addr  in  32  byte address.
req_wdata  in  32  store data; low bits are used for byte and half stores.
req_ready  out  1  request accepted on an edge where req_valid && req_ready.
stall  out  1  req_valid && !req_ready (combinational); freezes upstream stages.
rsp_valid  out  1  one-cycle pulse when the access completes (loads and stores).
rsp_rdata  out  32  extended load data; 0 for stores and errors.
misalign_err  out  1  valid with rsp_valid; the access was misaligned.

Behaviour:
- Reset (rst=0, asynchronous): state = IDLE, wait counter = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, misalign_err = 0. Memory contents are not cleared.
- Address indexing: only addr[log2(DEPTH_BYTES)-1:0] is used, so higher bits wrap silently.
- Misaligned access: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Memory is not accessed and no store occurs.
  - rsp_valid = 1, misalign_err = 1 and rsp_rdata = 0 in the cycle after accept, regardless of WAIT_CYCLES.
- Little-endian layout: byte k of the word goes to address addr+k.
  - Byte store writes wdata[7:0].
  - Half store writes wdata[15:0] to addr and addr+1.
- Load extension:
  - Byte loads sign-extend bit 7 (or zero-extend when req_unsigned = 1).
  - Half loads sign-extend bit 15 (or zero-extend when req_unsigned = 1).
  - Word loads are returned unchanged.
- State machine (states IDLE, WAIT):
  - IDLE: req_ready = 1. When a request is accepted at edge E0:
    - Misaligned, or WAIT_CYCLES = 0: access (if aligned) at E0. rsp_valid is high in the cycle after E0. State stays IDLE, so back-to-back accepts give one response per cycle.
    - Otherwise: latch addr, size, we, unsigned flag and wdata; load counter = WAIT_CYCLES; go to WAIT.
  - WAIT: req_ready = 0.
    - Counter decrements each edge.
    - At the edge where the counter is 1, the access commits (write or read sample) and the state returns to IDLE.
    - rsp_valid pulses in the following cycle.
    - Net timing: accept at E0, commit at E0+WAIT_CYCLES, and req_ready low for exactly WAIT_CYCLES cycles.
- Read-after-write: a load accepted at the edge after a store to the same address returns the new data. The write commits before the load's read sample.
- rsp_valid is high for exactly one cycle per accepted request; there is no backpressure on the response.
- Reset during WAIT: the pending access is abandoned with no write and no response. The block returns to IDLE.
- Inputs are ignored while req_ready = 0. Upstream must hold them, which stall guarantees.

Decomposition:
- Package riscv_pkg:
  - typedef enum mem_size_t {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10}.
  - typedef enum lsu_state_t {LSU_IDLE, LSU_WAIT}.
  - Localparam XLEN = 32.
- One combinational sub-module, lsu_align. It provides byte-lane enables plus shifted write data for stores, and right-shifting plus sign/zero extension for loads, so the FSM/memory wrapper only moves bytes.
- The memory array is named r_mem (byte array), so benches can preload it with $readmemh through a hierarchical path.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata = 0xDEADBEEF; r_mem[0x10..0x13] = EF, BE, AD, DE.
- Byte and half extension: after the word above:
  - LB @0x13 -> 0xFFFFFFDE
  - LBU @0x13 -> 0x000000DE
  - LH @0x12 -> 0xFFFFDEAD
  - LHU @0x10 -> 0x0000BEEF
- Partial stores: SB 0x12345677 @0x11, then LW @0x10 -> 0xDEAD77EF; SH 0xAAAA5555 @0x12, then LW @0x10 -> 0x555577EF.
- Misaligned: LW @0x16, SH @0x21 -> each gives rsp_valid with misalign_err = 1 and rdata = 0 one cycle after accept; memory is unchanged and a follow-up LW @0x20 returns the prior value.
- WAIT_CYCLES = 3: a request held valid -> stall high for 3 cycles, rsp_valid pulses once 4 cycles after accept; rst pulled low in WAIT during a store -> no write, no rsp_valid, req_ready = 1 after reset.
- Back-to-back with WAIT_CYCLES = 0: SW 0x1E @0x4 then LW @0x4 on consecutive cycles -> two rsp_valid pulses, load returns 0x0000001E; address 0x404 with DEPTH_BYTES = 1024 aliases to 0x4.
